// File: rtl/id_01_encoder_pkg.sv
// rtl/id_01_encoder_pkg.sv - class-01 opcodes, op_sel indices, field masks and word builder
package id_01_encoder_pkg;

    localparam logic [1:0] CLASS_PREFIX = 2'b01;

    localparam logic [4:0] OPC_INC  = 5'b10000;
    localparam logic [4:0] OPC_ADD  = 5'b10100;
    localparam logic [4:0] OPC_SUB  = 5'b10110;
    localparam logic [4:0] OPC_DEC  = 5'b10010;
    localparam logic [4:0] OPC_NEG  = 5'b10001;
    localparam logic [4:0] OPC_MOVA = 5'b01100;
    localparam logic [4:0] OPC_MOVB = 5'b01010;
    localparam logic [4:0] OPC_SHR  = 5'b11001;
    localparam logic [4:0] OPC_SHL  = 5'b11000;
    localparam logic [4:0] OPC_CLR  = 5'b00000;
    localparam logic [4:0] OPC_SET  = 5'b01111;
    localparam logic [4:0] OPC_NOT  = 5'b00011;
    localparam logic [4:0] OPC_AND  = 5'b01000;
    localparam logic [4:0] OPC_OR   = 5'b01110;
    localparam logic [4:0] OPC_XOR  = 5'b00110;
    localparam logic [4:0] OPC_MUL  = 5'b10111;
    localparam logic [4:0] OPC_ADC  = 5'b10101;
    localparam logic [4:0] OPC_ASR  = 5'b11011;

    typedef enum logic [4:0] {
        OP_INC  = 5'd0,  OP_ADD  = 5'd1,  OP_SUB = 5'd2,  OP_DEC = 5'd3,
        OP_NEG  = 5'd4,  OP_MOVA = 5'd5,  OP_MOVB = 5'd6, OP_SHR = 5'd7,
        OP_SHL  = 5'd8,  OP_CLR  = 5'd9,  OP_SET = 5'd10, OP_NOT = 5'd11,
        OP_AND  = 5'd12, OP_OR   = 5'd13, OP_XOR = 5'd14, OP_MUL = 5'd15,
        OP_ADC  = 5'd16, OP_ASR  = 5'd17
    } op_sel_e;

    // Mask bits {keep_rd, keep_ra, keep_rb}; a cleared bit forces that field to 000.
    localparam logic [2:0] MASK_BIN    = 3'b111;
    localparam logic [2:0] MASK_UNARY  = 3'b110;
    localparam logic [2:0] MASK_MOVB   = 3'b101;
    localparam logic [2:0] MASK_RDONLY = 3'b100;

    typedef struct packed {
        logic       valid;
        logic [4:0] opcode;
        logic [2:0] mask;
    } op_info_t;

    function automatic logic [15:0] build_word(input logic [4:0] opcode, input logic [2:0] mask,
                                               input logic [2:0] rd, input logic [2:0] ra,
                                               input logic [2:0] rb);
        return {CLASS_PREFIX, opcode,
                mask[2] ? rd : 3'b000,
                mask[1] ? ra : 3'b000,
                mask[0] ? rb : 3'b000};
    endfunction

endpackage

// File: rtl/id_01_encoder_if.sv
// rtl/id_01_encoder_if.sv - request, load and program-memory write bus of the encoder
interface id_01_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        op_sel;
    logic [2:0]        rd;
    logic [2:0]        ra;
    logic [2:0]        rb;
    logic              load_addr;
    logic [ADDR_W-1:0] start_addr;
    logic              mem_we;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_full;
    logic              err_op;
    logic [7:0]        err_count;
    logic [ADDR_W:0]   words_written;

    modport slave (
        input  in_valid, op_sel, rd, ra, rb, load_addr, start_addr, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, mem_full, err_op, err_count, words_written
    );

    modport master (
        output in_valid, op_sel, rd, ra, rb, load_addr, start_addr, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, mem_full, err_op, err_count, words_written
    );
endinterface

// File: rtl/id_01_encoder_sync_fifo.sv
// rtl/id_01_encoder_sync_fifo.sv - single-clock FIFO, power-of-two depth, show-ahead head
// Ports: clk, resetn (sync active-low), push_i/push_data_i, pop_i, head_o, full_o, empty_o.
module id_01_encoder_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed once counted as valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/id_01_encoder.sv
// rtl/id_01_encoder.sv - encodes symbolic ALU ops into class-01 words and streams them to program memory
// Ports: clk, resetn (sync active-low); bus (slave): in_valid/in_ready/op_sel/rd/ra/rb request,
// load_addr/start_addr pointer load, mem_we/mem_ready/mem_addr/mem_wdata write port,
// mem_full, err_op, err_count, words_written status.
module id_01_encoder
    import id_01_encoder_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter bit WRAP_EN    = 1'b0
) (
    input logic           clk,
    input logic           resetn,
    id_01_encoder_if.slave bus
);
    localparam logic [ADDR_W:0]   WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    op_info_t          info;
    logic [15:0]       enc_word;
    logic [15:0]       fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              push;
    logic              mem_wr;
    logic              load_ok;

    logic [ADDR_W-1:0] ptr_q,      ptr_d;
    logic              mem_full_q, mem_full_d;
    logic              err_op_q,   err_op_d;
    logic [7:0]        err_cnt_q,  err_cnt_d;
    logic [ADDR_W:0]   words_q,    words_d;

    always_comb begin
        info = '{valid: 1'b0, opcode: 5'b00000, mask: 3'b000};
        case (bus.op_sel)
            OP_ADD:  info = '{1'b1, OPC_ADD,  MASK_BIN};
            OP_SUB:  info = '{1'b1, OPC_SUB,  MASK_BIN};
            OP_AND:  info = '{1'b1, OPC_AND,  MASK_BIN};
            OP_OR:   info = '{1'b1, OPC_OR,   MASK_BIN};
            OP_XOR:  info = '{1'b1, OPC_XOR,  MASK_BIN};
            OP_MUL:  info = '{1'b1, OPC_MUL,  MASK_BIN};
            OP_ADC:  info = '{1'b1, OPC_ADC,  MASK_BIN};
            OP_INC:  info = '{1'b1, OPC_INC,  MASK_UNARY};
            OP_DEC:  info = '{1'b1, OPC_DEC,  MASK_UNARY};
            OP_NEG:  info = '{1'b1, OPC_NEG,  MASK_UNARY};
            OP_MOVA: info = '{1'b1, OPC_MOVA, MASK_UNARY};
            OP_SHR:  info = '{1'b1, OPC_SHR,  MASK_UNARY};
            OP_SHL:  info = '{1'b1, OPC_SHL,  MASK_UNARY};
            OP_NOT:  info = '{1'b1, OPC_NOT,  MASK_UNARY};
            OP_ASR:  info = '{1'b1, OPC_ASR,  MASK_UNARY};
            OP_MOVB: info = '{1'b1, OPC_MOVB, MASK_MOVB};
            OP_CLR:  info = '{1'b1, OPC_CLR,  MASK_RDONLY};
            OP_SET:  info = '{1'b1, OPC_SET,  MASK_RDONLY};
            default: info = '{valid: 1'b0, opcode: 5'b00000, mask: 3'b000};
        endcase
    end

    assign enc_word = build_word(info.opcode, info.mask, bus.rd, bus.ra, bus.rb);

    // Invalid requests still complete the handshake; they just never reach the FIFO.
    assign bus.in_ready = !fifo_full && !mem_full_q;
    assign accept       = bus.in_valid && bus.in_ready;
    assign push         = accept && info.valid;
    // A load is only honoured with nothing buffered, so it can never collide with a write.
    assign load_ok      = bus.load_addr && fifo_empty;
    assign bus.mem_we   = !fifo_empty && !mem_full_q;
    assign mem_wr       = bus.mem_we && bus.mem_ready;

    id_01_encoder_sync_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (push),
        .push_data_i (enc_word),
        .pop_i       (mem_wr),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        ptr_d      = ptr_q;
        mem_full_d = mem_full_q;
        words_d    = words_q;
        err_op_d   = accept && !info.valid;
        err_cnt_d  = err_cnt_q;
        if (err_op_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
        if (load_ok) begin
            ptr_d      = bus.start_addr;
            mem_full_d = 1'b0;
            words_d    = '0;
        end else if (mem_wr) begin
            if (words_q != WORDS_MAX) words_d = words_q + 1'b1;
            if (ptr_q == ADDR_LAST) begin
                if (WRAP_EN) ptr_d = '0;
                else         mem_full_d = 1'b1;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr_q      <= '0;
            mem_full_q <= 1'b0;
            words_q    <= '0;
            err_op_q   <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            ptr_q      <= ptr_d;
            mem_full_q <= mem_full_d;
            words_q    <= words_d;
            err_op_q   <= err_op_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.mem_addr      = ptr_q;
    assign bus.mem_wdata     = fifo_empty ? 16'h0000 : fifo_head;
    assign bus.mem_full      = mem_full_q;
    assign bus.err_op        = err_op_q;
    assign bus.err_count     = err_cnt_q;
    assign bus.words_written = words_q;

endmodule
